// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter granting one of four requesters write access
// to a downstream FIFO, up to BURST_MAX beats per grant.
module fifo_wr_arbiter #(
   parameter int DATA_W    = 8,
   parameter int BURST_MAX = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [3:0]            req,
   input  logic [4*DATA_W-1:0]   din_bus,
   output logic [3:0]            ack,
   input  logic                  fifo_full,
   output logic                  fifo_wr,
   output logic [DATA_W-1:0]     fifo_din,
   output logic [1:0]            grant_id,
   output logic                  busy
);

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   state_t     state_q, state_d;
   logic [1:0] grant_q, grant_d;
   logic [1:0] rr_q, rr_d;
   logic [2:0] cnt_q, cnt_d;

   logic       beat;
   logic       last_beat;
   logic [1:0] pick;
   logic [1:0] idx;
   logic       found;

   assign busy     = (state_q == BURST);
   assign grant_id = grant_q;
   assign beat     = busy && req[grant_q] && !fifo_full;
   assign fifo_wr  = beat;
   assign ack      = beat ? (4'b0001 << grant_q) : 4'b0000;
   assign fifo_din = busy ? din_bus[32'(grant_q)*DATA_W +: DATA_W]
                          : '0;

   // 4-bit compare so BURST_MAX = 8 is reachable from a 3-bit counter
   assign last_beat = (({1'b0, cnt_q} + 4'd1) == 4'(BURST_MAX));

   always_comb begin
      pick  = rr_q;
      idx   = '0;
      found = 1'b0;
      for (int i = 0; i < 4; i++) begin
         idx = rr_q + 2'(i);
         if (!found && req[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      rr_d    = rr_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (|req) begin
               state_d = BURST;
               grant_d = pick;
               cnt_d   = '0;
            end
         end
         BURST: begin
            if (!req[grant_q]) begin
               state_d = IDLE;
               rr_d    = grant_q + 2'd1;
            end else if (beat) begin
               cnt_d = cnt_q + 3'd1;
               if (last_beat) begin
                  state_d = IDLE;
                  rr_d    = grant_q + 2'd1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         grant_q <= '0;
         rr_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         rr_q    <= rr_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: reset, bursts, round-robin,
// backpressure, early release, FIFO fill and mid-burst reset.
module tb_fifo_wr_arbiter;

   localparam int DW = 8;

   logic          clk;
   logic          reset;
   logic [3:0]    req;
   logic [4*DW-1:0] din_bus;
   logic [3:0]    ack;
   logic          fifo_full;
   logic          fifo_wr;
   logic [DW-1:0] fifo_din;
   logic [1:0]    grant_id;
   logic          busy;

   logic [7:0]    base [4];
   logic [7:0]    cnt  [4];
   logic          full_ovr;
   logic          use_fifo;
   logic [7:0]    fq[$];
   int            fcnt;

   int tests_run;
   int tests_failed;

   fifo_wr_arbiter #(.DATA_W(DW), .BURST_MAX(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .din_bus   (din_bus),
      .ack       (ack),
      .fifo_full (fifo_full),
      .fifo_wr   (fifo_wr),
      .fifo_din  (fifo_din),
      .grant_id  (grant_id),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // requester model: each source advances its word on its own ack
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) cnt[i] <= 8'd0;
      end else begin
         for (int i = 0; i < 4; i++)
            if (ack[i]) cnt[i] <= cnt[i] + 8'd1;
      end
   end

   always_comb begin
      din_bus = '0;
      for (int i = 0; i < 4; i++)
         din_bus[i*DW +: DW] = base[i] + cnt[i];
   end

   // 8-deep downstream FIFO model, write side only
   initial fcnt = 0;
   always @(posedge clk) begin
      if (use_fifo && fifo_wr && fcnt < 8) begin
         fq.push_back(fifo_din);
         fcnt <= fcnt + 1;
      end
   end

   assign fifo_full = use_fifo ? (fcnt >= 8) : full_ovr;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_wr"}, 32'(fifo_wr), 32'd0);
      chk({tag, "_ack"}, 32'(ack), 32'd0);
      chk({tag, "_din"}, 32'(fifo_din), 32'd0);
   endtask

   task automatic chk_beat(input string tag, input int g,
                           input logic [7:0] d);
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_gnt"}, 32'(grant_id), 32'(g));
      chk({tag, "_wr"}, 32'(fifo_wr), 32'd1);
      chk({tag, "_ack"}, 32'(ack), 32'(4'b0001 << g));
      chk({tag, "_din"}, 32'(fifo_din), 32'(d));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      #1;
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      reset    = 1'b1;
      req      = 4'b1111;
      full_ovr = 1'b0;
      use_fifo = 1'b0;
      base[0] = 8'h01;
      base[1] = 8'h40;
      base[2] = 8'h30;
      base[3] = 8'h60;

      // reset holds everything quiet despite active requests
      tick();
      tick();
      chk_idle("rst");
      chk("rst_gnt", 32'(grant_id), 32'd0);

      // single requester, data 1..4 then new burst with 5
      req = 4'b0001;
      reset = 1'b0;
      #1;
      chk_idle("s_idle0");
      tick();
      chk_beat("s_b1", 0, 8'd1);
      tick();
      chk_beat("s_b2", 0, 8'd2);
      tick();
      chk_beat("s_b3", 0, 8'd3);
      tick();
      chk_beat("s_b4", 0, 8'd4);
      tick();
      chk_idle("s_gap");
      tick();
      chk_beat("s_b5", 0, 8'd5);

      // asynchronous reset mid-burst clears outputs at once
      reset = 1'b1;
      #1;
      chk_idle("s_rst");

      // round robin 0,1,2,3,0 with full bursts and idle gaps
      req = 4'b1111;
      tick();
      reset = 1'b0;
      #1;
      chk("rr_idle", 32'(busy), 32'd0);
      tick();
      for (int r = 0; r < 5; r++) begin
         for (int b = 0; b < 4; b++) begin
            chk("rr_busy", 32'(busy), 32'd1);
            chk("rr_gnt", 32'(grant_id), 32'(r % 4));
            chk("rr_ack", 32'(ack), 32'(4'b0001 << (r % 4)));
            tick();
         end
         chk("rr_gap", 32'(busy), 32'd0);
         tick();
      end

      // backpressure on requester 2 after beat 2
      req = 4'b0100;
      do_reset();
      tick();
      chk_beat("bp_b1", 2, 8'h30);
      tick();
      chk_beat("bp_b2", 2, 8'h31);
      tick();
      full_ovr = 1'b1;
      for (int s = 0; s < 3; s++) begin
         #1;
         chk("bp_st_wr", 32'(fifo_wr), 32'd0);
         chk("bp_st_ack", 32'(ack), 32'd0);
         chk("bp_st_busy", 32'(busy), 32'd1);
         chk("bp_st_gnt", 32'(grant_id), 32'd2);
         tick();
      end
      full_ovr = 1'b0;
      #1;
      chk_beat("bp_b3", 2, 8'h32);
      tick();
      chk_beat("bp_b4", 2, 8'h33);
      tick();
      chk_idle("bp_end");

      // early release by requester 1, then 3 beats 0 from rr_ptr=2
      req = 4'b1010;
      do_reset();
      tick();
      chk_beat("er_b1", 1, 8'h40);
      tick();
      chk_beat("er_b2", 1, 8'h41);
      tick();
      req = 4'b1001;
      #1;
      chk("er_drop_wr", 32'(fifo_wr), 32'd0);
      chk("er_drop_ack", 32'(ack), 32'd0);
      tick();
      chk_idle("er_idle");
      tick();
      chk_beat("er_g3_b1", 3, 8'h60);
      tick();
      chk_beat("er_g3_b2", 3, 8'h61);

      // reset during beat 2 of requester 3; arbitration restarts at 0
      reset = 1'b1;
      #1;
      chk_idle("mr_rst");
      req = 4'b1010;
      tick();
      reset = 1'b0;
      #1;
      chk_idle("mr_rel");
      tick();
      chk_beat("mr_gnt", 1, 8'h40);

      // FIFO integration: fill 8 entries, then stall on full
      base[0] = 8'h10;
      base[2] = 8'h20;
      req = 4'b0101;
      reset = 1'b1;
      tick();
      use_fifo = 1'b1;
      tick();
      reset = 1'b0;
      for (int c = 0; c < 11; c++) tick();
      chk("ff_cnt", 32'(fcnt), 32'd8);
      chk("ff_full", 32'(fifo_full), 32'd1);
      chk("ff_busy", 32'(busy), 32'd1);
      chk("ff_gnt", 32'(grant_id), 32'd0);
      chk("ff_wr", 32'(fifo_wr), 32'd0);
      chk("ff_ack", 32'(ack), 32'd0);
      req = 4'b0000;
      tick();
      tick();
      chk("ff_cnt2", 32'(fcnt), 32'd8);
      begin
         logic [7:0] exp_q [8];
         exp_q = '{8'h10, 8'h11, 8'h12, 8'h13,
                   8'h20, 8'h21, 8'h22, 8'h23};
         for (int k = 0; k < 8; k++) begin
            if (fq.size() > 0)
               chk("ff_drain", 32'(fq.pop_front()), 32'(exp_q[k]));
            else
               chk("ff_drain_empty", 32'(k), 32'd8);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
